// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
// Holds the FSM state encoding and the fixed sizing constants of the datapath.
package shift_add_mult_ctrl_pkg;

    // Operand width; tied to the width of the shared ripple adder.
    localparam int WIDTH     = 32'sd16;
    // Iteration counter width; must be able to hold WIDTH.
    localparam int CNT_W     = 32'sd5;
    // Counter value of the final add/shift step.
    localparam int LAST_STEP = 32'sd15;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : shift_add_mult_ctrl_pkg

// File: rtl/rippleAdder_16bit.sv
// Existing 16-bit ripple-carry adder of the adder datapath.
// Bit-serial carry chain built from full-adder equations; purely combinational.
module rippleAdder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry_s;

    // Full-adder chain: each bit produces its sum and the carry into the next bit.
    always_comb begin
        carry_s    = 17'd0;
        sum        = 16'd0;
        carry_s[0] = cin;
        for (int i = 0; i < 16; i++) begin
            sum[i]       = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
        cout = carry_s[16];
    end

endmodule : rippleAdder_16bit

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 16x16 unsigned multiplier controller.
// Reuses one rippleAdder_16bit per cycle in shift-and-add form: the low half of
// the accumulator starts out holding the multiplier, and each step adds the
// multiplicand into the high half when the current multiplier bit is set, then
// shifts the whole {carry, high, low} word right by one.
module shift_add_mult_ctrl #(
    parameter int WIDTH = shift_add_mult_ctrl_pkg::WIDTH,
    parameter int CNT_W = shift_add_mult_ctrl_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import shift_add_mult_ctrl_pkg::*;

    // Registered state
    state_t               state_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     acc_hi_r;
    logic [WIDTH-1:0]     acc_lo_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    // Next-state values
    state_t               state_s;
    logic [WIDTH-1:0]     mcand_s;
    logic [WIDTH-1:0]     acc_hi_s;
    logic [WIDTH-1:0]     acc_lo_s;
    logic [CNT_W-1:0]     cnt_s;
    logic                 busy_s;
    logic                 done_s;
    logic [2*WIDTH-1:0]   product_s;

    // Adder interface
    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;

    // Select the multiplicand or zero depending on the current multiplier bit.
    always_comb begin
        if (acc_lo_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
    end

    // The only arithmetic element on the data path; carry-in is never used.
    rippleAdder_16bit u_adder (acc_hi_r, addend_s, 1'b0, sum_s, cout_s);

    // Next-state, datapath update and output decode of the controller.
    always_comb begin
        state_s   = state_r;
        mcand_s   = mcand_r;
        acc_hi_s  = acc_hi_r;
        acc_lo_s  = acc_lo_r;
        cnt_s     = cnt_r;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        product_s = product_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mcand_s  = a;
                    acc_hi_s = {WIDTH{1'b0}};
                    acc_lo_s = b;
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = ST_CALC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_CALC: begin
                if (cnt_r > CNT_W'(LAST_STEP)) begin
                    // Counter outside its legal range: abandon the job.
                    state_s = ST_IDLE;
                end else begin
                    // cout enters at the top, so no partial sum can overflow.
                    acc_hi_s = {cout_s, sum_s[WIDTH-1:1]};
                    acc_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
                    cnt_s    = cnt_r + CNT_W'(1);
                    busy_s   = 1'b1;
                    if (cnt_r == CNT_W'(LAST_STEP)) begin
                        // Capture the result together with the final shift so
                        // it is valid in the same cycle as done.
                        product_s = {cout_s, sum_s, acc_lo_r[WIDTH-1:1]};
                        done_s    = 1'b1;
                        state_s   = ST_DONE;
                    end else begin
                        state_s   = ST_CALC;
                    end
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_s;
            mcand_r   <= mcand_s;
            acc_hi_r  <= acc_hi_s;
            acc_lo_r  <= acc_lo_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            product_r <= product_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule : shift_add_mult_ctrl

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl.
// Stimulus pushes expected products (with their acceptance cycle) into a
// scoreboard; a monitor pops and compares whenever done is seen. Direct
// observations from the stimulus side are queued and judged by the same monitor.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    typedef struct {
        logic [31:0] prod;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    exp_t sb[$];
    chk_t chk_q[$];

    int cyc      = 0;
    int n_vec    = 0;
    int n_fail   = 0;
    int busy_run = 0;

    shift_add_mult_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: judges queued direct checks and every done pulse.
    initial begin
        chk_t c;
        exp_t e;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_vec = n_vec + 1;
                if (c.got !== c.exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %h, expected %h", c.name, c.got, c.exp);
                end
            end
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run = busy_run + 1;
                else      busy_run = 0;
                if (done) begin
                    n_vec = n_vec + 1;
                    if (sb.size() == 0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL extra_done: done with product %h at cycle %0d, expected none", product, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (product !== e.prod) begin
                            n_fail = n_fail + 1;
                            $display("FAIL product: got %h, expected %h", product, e.prod);
                        end
                        n_vec = n_vec + 1;
                        if (cyc - e.acc_cyc != 16) begin
                            n_fail = n_fail + 1;
                            $display("FAIL done_latency: got %0d edges, expected 16", cyc - e.acc_cyc);
                        end
                        n_vec = n_vec + 1;
                        if (busy_run != 17) begin
                            n_fail = n_fail + 1;
                            $display("FAIL busy_len: got %0d cycles, expected 17", busy_run);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // One-cycle start pulse; when track is set the job's result is expected.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp_p, input bit track);
        exp_t e;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            e.prod    = exp_p;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        #7;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic job, then product must hold in IDLE.
        issue(16'd5, 16'd9, 32'd45, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("product_hold", product, 32'd45);

        // Jobs restarted at the earliest legal edge.
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        repeat (17) @(posedge clk);
        issue(16'd111, 16'd41, 32'd4551, 1'b1);
        repeat (17) @(posedge clk);
        issue(16'd0, 16'd1234, 32'd0, 1'b1);
        repeat (17) @(posedge clk);
        issue(16'd1234, 16'd0, 32'd0, 1'b1);
        repeat (20) @(posedge clk);

        // Start re-pulsed during CALC must be ignored.
        issue(16'd7, 16'd6, 32'd42, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a     = 16'd2;
        b     = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("product_after_ignore", product, 32'd42);

        // Reset during CALC step 8 aborts the job without a done.
        issue(16'd300, 16'd200, 32'd60000, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", product, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd15, 16'd9, 32'd135, 1'b1);
        repeat (20) @(posedge clk);

        // Start held high: back-to-back jobs every 18 cycles.
        @(negedge clk);
        a     = 16'd2;
        b     = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.prod    = 32'd6;
        e.acc_cyc = cyc;
        sb.push_back(e);
        for (int j = 0; j < 2; j++) begin
            repeat (18) @(posedge clk);
            #1;
            e.prod    = 32'd6;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        start = 1'b0;
        repeat (24) @(posedge clk);

        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_shift_add_mult_ctrl
